wb_arbiter: RTL and testbench

//  Shares one Wishbone classic master port between two requesters.
//  m0 is instruction fetch; m1 is the load-store unit.

---
 rtl/wb_arbiter.sv | 164 ++++++++++++++++
 tb/tb_wb_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Two-requester Wishbone classic arbiter. m0 is instruction fetch and m1 is the load-store unit.
// Arbitration is round-robin, and the grant is held for the whole bus cycle.
// A watchdog turns a strobe that is never acknowledged into an error, so the core cannot hang.
module wb_arbiter #(
  parameter int unsigned TIMEOUT = 16,  // 0 disables the watchdog
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rstn_i,
  // requester 0 (fetch)
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  // requester 1 (load-store)
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  // shared bus
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  input  logic        s_err_i
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StBusy  = 2'd1;
  localparam logic [1:0] StAbort = 2'd2;

  localparam bit              WdogEn   = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] WdogLast = CNT_W'(TIMEOUT - 1);

  logic [1:0]       state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] wdog_q, wdog_d;
  logic             abort_new_q, abort_new_d;  // high only in the first ABORT cycle

  logic        own_cyc, own_stb, own_we;
  logic [3:0]  own_sel;
  logic [31:0] own_adr, own_dat;
  logic        slave_resp;

  // Select the current owner's request signals.
  always_comb begin
    own_cyc = owner_q ? m1_cyc_i : m0_cyc_i;
    own_stb = owner_q ? m1_stb_i : m0_stb_i;
    own_we  = owner_q ? m1_we_i  : m0_we_i;
    own_sel = owner_q ? m1_sel_i : m0_sel_i;
    own_adr = owner_q ? m1_adr_i : m0_adr_i;
    own_dat = owner_q ? m1_dat_i : m0_dat_i;
  end

  assign slave_resp = s_ack_i | s_err_i;

  // Arbitration, grant hold and watchdog next-state logic.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    wdog_d      = '0;
    abort_new_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (m0_cyc_i && m1_cyc_i) begin
          owner_d = ~last_q;
          state_d = StBusy;
        end else if (m0_cyc_i) begin
          owner_d = 1'b0;
          state_d = StBusy;
        end else if (m1_cyc_i) begin
          owner_d = 1'b1;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (!own_cyc) begin
          state_d = StIdle;
          last_d  = owner_q;
        end else if (own_stb && !slave_resp) begin
          if (WdogEn && (wdog_q == WdogLast)) begin
            state_d     = StAbort;
            abort_new_d = 1'b1;
          end else begin
            wdog_d = wdog_q + 1'b1;
          end
        end
      end
      StAbort: begin
        if (!own_cyc) begin
          state_d = StIdle;
          last_d  = owner_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset returns to IDLE with m0 winning the first tie.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= StIdle;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      wdog_q      <= '0;
      abort_new_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      wdog_q      <= wdog_d;
      abort_new_q <= abort_new_d;
    end
  end

  // Bus and response routing; everything is zero outside BUSY except the abort error pulse.
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_sel_o  = '0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    if (state_q == StBusy) begin
      s_cyc_o  = own_cyc;
      s_stb_o  = own_stb;
      s_we_o   = own_we;
      s_sel_o  = own_sel;
      s_adr_o  = own_adr;
      s_dat_o  = own_dat;
      m0_ack_o = ~owner_q & s_ack_i;
      m0_err_o = ~owner_q & s_err_i;
      m1_ack_o = owner_q & s_ack_i;
      m1_err_o = owner_q & s_err_i;
    end else if (state_q == StAbort && abort_new_q) begin
      m0_err_o = ~owner_q;
      m1_err_o = owner_q;
    end
  end

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reset, single read, round-robin ties, burst gap,
// watchdog abort and reset in mid-transfer.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rstn_i;
  logic        m0_cyc_i, m0_stb_i, m0_we_i;
  logic [3:0]  m0_sel_i;
  logic [31:0] m0_adr_i, m0_dat_i, m0_dat_o;
  logic        m0_ack_o, m0_err_o;
  logic        m1_cyc_i, m1_stb_i, m1_we_i;
  logic [3:0]  m1_sel_i;
  logic [31:0] m1_adr_i, m1_dat_i, m1_dat_o;
  logic        m1_ack_o, m1_err_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_adr_o, s_dat_o, s_dat_i;
  logic        s_ack_i, s_err_i;

  always #5 clk = ~clk;

  wb_arbiter #(
    .TIMEOUT (4),
    .CNT_W   (8)
  ) dut (
    .clk      (clk),
    .rstn_i   (rstn_i),
    .m0_cyc_i (m0_cyc_i),
    .m0_stb_i (m0_stb_i),
    .m0_we_i  (m0_we_i),
    .m0_sel_i (m0_sel_i),
    .m0_adr_i (m0_adr_i),
    .m0_dat_i (m0_dat_i),
    .m0_dat_o (m0_dat_o),
    .m0_ack_o (m0_ack_o),
    .m0_err_o (m0_err_o),
    .m1_cyc_i (m1_cyc_i),
    .m1_stb_i (m1_stb_i),
    .m1_we_i  (m1_we_i),
    .m1_sel_i (m1_sel_i),
    .m1_adr_i (m1_adr_i),
    .m1_dat_i (m1_dat_i),
    .m1_dat_o (m1_dat_o),
    .m1_ack_o (m1_ack_o),
    .m1_err_o (m1_err_o),
    .s_cyc_o  (s_cyc_o),
    .s_stb_o  (s_stb_o),
    .s_we_o   (s_we_o),
    .s_sel_o  (s_sel_o),
    .s_adr_o  (s_adr_o),
    .s_dat_o  (s_dat_o),
    .s_dat_i  (s_dat_i),
    .s_ack_i  (s_ack_i),
    .s_err_i  (s_err_i)
  );

  // Status word layout: {s_cyc, s_stb, m0_ack, m0_err, m1_ack, m1_err}
  localparam logic [31:0] SZero  = 32'b000000;
  localparam logic [31:0] SBus   = 32'b110000;
  localparam logic [31:0] SGap   = 32'b100000;
  localparam logic [31:0] SM0Ack = 32'b111000;
  localparam logic [31:0] SM0AE  = 32'b111100;
  localparam logic [31:0] SM1Ack = 32'b110010;
  localparam logic [31:0] SM1Err = 32'b000001;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic logic [31:0] st();
    return {26'd0, s_cyc_o, s_stb_o, m0_ack_o, m0_err_o, m1_ack_o, m1_err_o};
  endfunction

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL sb_empty observed=%h expected=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  // Drive point is 1 time unit after the rising edge; sampling happens on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  // One cycle where only the status word is checked.
  task automatic stat(input string tag, input logic [31:0] exp_st);
    push(tag, exp_st);
    samp();
    pop_chk(st());
    tick();
  endtask

  task automatic m0_req(input logic [31:0] adr);
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = 1'b0; m0_sel_i = 4'hF; m0_adr_i = adr;
  endtask

  task automatic m0_drop();
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
  endtask

  task automatic m1_drop();
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rstn_i = 1'b0;
    m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_sel_i = 0; m0_adr_i = 0; m0_dat_i = 0;
    m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_sel_i = 0; m1_adr_i = 0; m1_dat_i = 0;
    s_dat_i = 0; s_ack_i = 0; s_err_i = 0;

    // Reset and idle
    repeat (3) tick();
    stat("in_reset", SZero);
    rstn_i = 1'b1;
    for (int i = 0; i < 10; i++) stat("idle", SZero);

    // m0 read of 0x100
    m0_req(32'h100);
    stat("rd_c0_no_grant", SZero);
    push("rd_c1_status", SBus); push("rd_c1_adr", 32'h100); push("rd_c1_we", 32'd0);
    samp(); pop_chk(st()); pop_chk(s_adr_o); pop_chk({31'd0, s_we_o});
    tick();
    stat("rd_c2_wait", SBus);
    s_ack_i = 1'b1; s_dat_i = 32'hDEAD_BEEF;
    push("rd_c3_status", SM0Ack); push("rd_c3_dat", 32'hDEAD_BEEF);
    samp(); pop_chk(st()); pop_chk(m0_dat_o);
    tick();
    s_ack_i = 1'b0; s_dat_i = 32'h0; m0_drop();
    stat("rd_c4_drop", SZero);
    stat("rd_c5_idle", SZero);

    // Reset pulse restores last=1 so the next tie goes to m0
    rstn_i = 1'b0;
    stat("reset_pulse", SZero);
    rstn_i = 1'b1;

    // Tie: m0 read and m1 write together
    m0_req(32'h200);
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b1; m1_sel_i = 4'b0011;
    m1_adr_i = 32'h300; m1_dat_i = 32'h1234_5678;
    stat("tie_c0", SZero);
    push("tie_c1_status", SBus); push("tie_c1_adr_m0", 32'h200);
    samp(); pop_chk(st()); pop_chk(s_adr_o);
    tick();
    s_ack_i = 1'b1; s_dat_i = 32'hA5A5_A5A5;
    stat("tie_m0_ack", SM0Ack);
    s_ack_i = 1'b0; m0_drop();
    stat("tie_m0_drop", SZero);
    m0_req(32'h400);  // re-request during the separating IDLE cycle: tie again
    stat("tie_gap_idle", SZero);
    push("m1_status", SBus); push("m1_adr", 32'h300); push("m1_we", 32'd1);
    push("m1_sel", 32'h3); push("m1_dat", 32'h1234_5678);
    samp();
    pop_chk(st()); pop_chk(s_adr_o); pop_chk({31'd0, s_we_o});
    pop_chk({28'd0, s_sel_o}); pop_chk(s_dat_o);
    tick();
    s_ack_i = 1'b1;
    stat("m1_ack_only", SM1Ack);
    s_ack_i = 1'b0; m1_drop();
    stat("m1_drop", SZero);
    stat("m1_gap_idle", SZero);
    push("m0_regrant_status", SBus); push("m0_regrant_adr", 32'h400);
    samp(); pop_chk(st()); pop_chk(s_adr_o);
    tick();

    // Burst gap longer than the timeout: grant kept, no abort
    m0_stb_i = 1'b0;
    for (int i = 0; i < 6; i++) stat("burst_gap", SGap);
    m0_stb_i = 1'b1; s_ack_i = 1'b1; s_err_i = 1'b1;
    stat("ack_and_err", SM0AE);
    s_ack_i = 1'b0; s_err_i = 1'b0; m0_drop();
    stat("gap_drop", SZero);
    stat("gap_idle", SZero);

    // Watchdog: m1 strobes and the slave never answers
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b0; m1_adr_i = 32'h500;
    stat("wd_c0", SZero);
    for (int i = 0; i < 4; i++) stat("wd_busy", SBus);
    m0_req(32'h600);  // m0 asks while m1 is being aborted
    stat("wd_abort_err", SM1Err);
    s_ack_i = 1'b1;   // late ack must be ignored
    stat("wd_late_ack", SZero);
    s_ack_i = 1'b0; m1_drop();
    stat("wd_m1_drop", SZero);
    stat("wd_idle", SZero);
    push("wd_m0_grant", SBus); push("wd_m0_adr", 32'h600);
    samp(); pop_chk(st()); pop_chk(s_adr_o);
    tick();
    s_ack_i = 1'b1;
    stat("wd_m0_ack", SM0Ack);
    s_ack_i = 1'b0; m0_drop();
    stat("wd_m0_drop", SZero);
    stat("wd_m0_idle", SZero);

    // Reset while m1 owns the bus
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b1; m1_adr_i = 32'h700;
    stat("rst_c0", SZero);
    stat("rst_m1_owns", SBus);
    rstn_i = 1'b0; s_ack_i = 1'b1;
    push("rst_mid_status", SZero); push("rst_mid_adr", 32'h0);
    samp(); pop_chk(st()); pop_chk(s_adr_o);
    tick();
    m0_req(32'h800);
    stat("rst_held", SZero);
    rstn_i = 1'b1; s_ack_i = 1'b0;
    stat("rst_release_idle", SZero);
    push("rst_m0_first", SBus); push("rst_m0_adr", 32'h800);
    samp(); pop_chk(st()); pop_chk(s_adr_o);

    checks++;
    assert (sb.size() == 0) else begin
      failures++;
      $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
